// File: rtl/regfile_b_write_arbiter_if.sv
// Port-B write arbiter bus: three request channels, operand-fetch read addresses,
// and the registered register-file write port with stall/hazard feedback.
interface regfile_b_write_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              md_req;
  logic [ADDR_W-1:0] md_addr;
  logic [DATA_W-1:0] md_data;
  logic              md_ready;
  logic              ls_req;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_data;
  logic              ls_ready;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_ready;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [2:0]        grant;
  logic              stall;
  logic              hazard_a;
  logic              hazard_b;

  modport master (
    output md_req, md_addr, md_data, ls_req, ls_addr, ls_data,
           dbg_req, dbg_addr, dbg_data, rd_addr_a, rd_addr_b,
    input  md_ready, ls_ready, dbg_ready, rf_we, rf_waddr, rf_wdata,
           grant, stall, hazard_a, hazard_b
  );

  modport slave (
    input  md_req, md_addr, md_data, ls_req, ls_addr, ls_data,
           dbg_req, dbg_addr, dbg_data, rd_addr_a, rd_addr_b,
    output md_ready, ls_ready, dbg_ready, rf_we, rf_waddr, rf_wdata,
           grant, stall, hazard_a, hazard_b
  );
endinterface

// File: rtl/regfile_b_write_arbiter.sv
// Register-file port-B write arbiter: one holding entry per requester (md, ls, dbg),
// fixed md>ls>dbg priority with starvation promotion of debug, and hazard/stall export.
module regfile_b_write_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  regfile_b_write_arbiter_if.slave  bus
);
  localparam int NREQ = 3;
  localparam int MD   = 0;
  localparam int LS   = 1;
  localparam int DBG  = 2;

  logic [NREQ-1:0]   hold_valid_r;
  logic [ADDR_W-1:0] hold_addr_r [NREQ];
  logic [DATA_W-1:0] hold_data_r [NREQ];
  logic [1:0]        starve_cnt_r;
  logic              rf_we_r;
  logic [ADDR_W-1:0] rf_waddr_r;
  logic [DATA_W-1:0] rf_wdata_r;
  logic [NREQ-1:0]   grant_r;

  logic [NREQ-1:0]   req_s;
  logic [NREQ-1:0]   ready_s;
  logic [NREQ-1:0]   xfer_s;
  logic [NREQ-1:0]   issue_s;
  logic              promote_s;
  logic [ADDR_W-1:0] req_addr_s [NREQ];
  logic [DATA_W-1:0] req_data_s [NREQ];
  logic [ADDR_W-1:0] issue_addr_s;
  logic [DATA_W-1:0] issue_data_s;
  logic              hazard_a_s;
  logic              hazard_b_s;

  assign req_s[MD]       = bus.md_req;
  assign req_s[LS]       = bus.ls_req;
  assign req_s[DBG]      = bus.dbg_req;
  assign req_addr_s[MD]  = bus.md_addr;
  assign req_addr_s[LS]  = bus.ls_addr;
  assign req_addr_s[DBG] = bus.dbg_addr;
  assign req_data_s[MD]  = bus.md_data;
  assign req_data_s[LS]  = bus.ls_data;
  assign req_data_s[DBG] = bus.dbg_data;

  assign promote_s = (starve_cnt_r == 2'(STARVE_MAX));

  // Issue selection: debug jumps the queue once it has lost STARVE_MAX times in a row.
  always_comb begin
    issue_s = 3'b000;
    if (promote_s && hold_valid_r[DBG]) begin
      issue_s = 3'b100;
    end else if (hold_valid_r[MD]) begin
      issue_s = 3'b001;
    end else if (hold_valid_r[LS]) begin
      issue_s = 3'b010;
    end else if (hold_valid_r[DBG]) begin
      issue_s = 3'b100;
    end else begin
      issue_s = 3'b000;
    end
  end

  // Mux the selected holding entry onto the write port.
  always_comb begin
    issue_addr_s = {ADDR_W{1'b0}};
    issue_data_s = {DATA_W{1'b0}};
    case (issue_s)
      3'b001: begin
        issue_addr_s = hold_addr_r[MD];
        issue_data_s = hold_data_r[MD];
      end
      3'b010: begin
        issue_addr_s = hold_addr_r[LS];
        issue_data_s = hold_data_r[LS];
      end
      3'b100: begin
        issue_addr_s = hold_addr_r[DBG];
        issue_data_s = hold_data_r[DBG];
      end
      default: begin
        issue_addr_s = {ADDR_W{1'b0}};
        issue_data_s = {DATA_W{1'b0}};
      end
    endcase
  end

  // An entry issuing this cycle can be refilled on the same edge, giving 1 write/cycle.
  assign ready_s = ~hold_valid_r | issue_s;
  assign xfer_s  = req_s & ready_s;

  // Pending-write hazards against both operand-fetch read ports.
  always_comb begin
    hazard_a_s = rf_we_r && (rf_waddr_r == bus.rd_addr_a);
    hazard_b_s = rf_we_r && (rf_waddr_r == bus.rd_addr_b);
    for (int i = 0; i < NREQ; i++) begin
      hazard_a_s = hazard_a_s | (hold_valid_r[i] && (hold_addr_r[i] == bus.rd_addr_a));
      hazard_b_s = hazard_b_s | (hold_valid_r[i] && (hold_addr_r[i] == bus.rd_addr_b));
    end
  end

  assign bus.md_ready  = ready_s[MD];
  assign bus.ls_ready  = ready_s[LS];
  assign bus.dbg_ready = ready_s[DBG];
  assign bus.stall     = (req_s[MD] && !ready_s[MD]) || (req_s[LS] && !ready_s[LS]);
  assign bus.hazard_a  = hazard_a_s;
  assign bus.hazard_b  = hazard_b_s;
  assign bus.rf_we     = rf_we_r;
  assign bus.rf_waddr  = rf_waddr_r;
  assign bus.rf_wdata  = rf_wdata_r;
  assign bus.grant     = grant_r;

  // Holding entries: capture on transfer, release on issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_r <= 3'b000;
      for (int i = 0; i < NREQ; i++) begin
        hold_addr_r[i] <= {ADDR_W{1'b0}};
        hold_data_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (xfer_s[i]) begin
          hold_valid_r[i] <= 1'b1;
          hold_addr_r[i]  <= req_addr_s[i];
          hold_data_r[i]  <= req_data_s[i];
        end else if (issue_s[i]) begin
          hold_valid_r[i] <= 1'b0;
        end else begin
          hold_valid_r[i] <= hold_valid_r[i];
        end
      end
    end
  end

  // Debug starvation counter, saturating at 3.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_r <= 2'd0;
    end else if (hold_valid_r[DBG] && !issue_s[DBG]) begin
      if (starve_cnt_r != 2'd3) begin
        starve_cnt_r <= starve_cnt_r + 2'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= 2'd0;
    end
  end

  // Registered write port; address/data hold their last value when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= {ADDR_W{1'b0}};
      rf_wdata_r <= {DATA_W{1'b0}};
      grant_r    <= 3'b000;
    end else if (issue_s != 3'b000) begin
      rf_we_r    <= 1'b1;
      rf_waddr_r <= issue_addr_s;
      rf_wdata_r <= issue_data_s;
      grant_r    <= issue_s;
    end else begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= rf_waddr_r;
      rf_wdata_r <= rf_wdata_r;
      grant_r    <= 3'b000;
    end
  end
endmodule

// File: tb/tb_regfile_b_write_arbiter.sv
// Self-checking bench: behavioural port-B arbiter model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_regfile_b_write_arbiter;
  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 3;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  regfile_b_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  regfile_b_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: requester 0=md, 1=ls, 2=dbg.
  bit          m_hv [3];
  int          m_ha [3];
  logic [31:0] m_hd [3];
  int          m_starve;
  bit          m_we;
  int          m_waddr;
  logic [31:0] m_wdata;
  int          m_grant;
  bit          live;

  function automatic int pick();
    int order [3];
    if (m_starve == STARVE_MAX) order = '{2, 0, 1};
    else                        order = '{0, 1, 2};
    for (int k = 0; k < 3; k++) if (m_hv[order[k]]) return order[k];
    return -1;
  endfunction

  // Compare DUT against the model mid-cycle, then advance the model for the coming edge.
  initial begin
    int          sel;
    bit          rdy [3];
    bit          rq [3];
    int          ra [3];
    logic [31:0] rdat [3];
    bit          e_stall, e_ha, e_hb;
    live = 1'b0;
    forever begin
      @(negedge clk);
      rq[0] = bus.md_req;  ra[0] = int'(bus.md_addr);  rdat[0] = bus.md_data;
      rq[1] = bus.ls_req;  ra[1] = int'(bus.ls_addr);  rdat[1] = bus.ls_data;
      rq[2] = bus.dbg_req; ra[2] = int'(bus.dbg_addr); rdat[2] = bus.dbg_data;
      sel = pick();
      for (int k = 0; k < 3; k++) rdy[k] = !m_hv[k] || (sel == k);
      if (live) begin
        e_stall = (rq[0] && !rdy[0]) || (rq[1] && !rdy[1]);
        e_ha = m_we && (m_waddr == int'(bus.rd_addr_a));
        e_hb = m_we && (m_waddr == int'(bus.rd_addr_b));
        for (int k = 0; k < 3; k++) begin
          e_ha = e_ha || (m_hv[k] && m_ha[k] == int'(bus.rd_addr_a));
          e_hb = e_hb || (m_hv[k] && m_ha[k] == int'(bus.rd_addr_b));
        end
        check("md_ready", 32'(bus.md_ready), 32'(rdy[0]));
        check("ls_ready", 32'(bus.ls_ready), 32'(rdy[1]));
        check("dbg_ready", 32'(bus.dbg_ready), 32'(rdy[2]));
        check("stall", 32'(bus.stall), 32'(e_stall));
        check("hazard_a", 32'(bus.hazard_a), 32'(e_ha));
        check("hazard_b", 32'(bus.hazard_b), 32'(e_hb));
        check("rf_we", 32'(bus.rf_we), 32'(m_we));
        check("rf_waddr", 32'(bus.rf_waddr), 32'(m_waddr));
        check("rf_wdata", bus.rf_wdata, m_wdata);
        check("grant", 32'(bus.grant), 32'(m_grant));
      end
      if (reset) begin
        for (int k = 0; k < 3; k++) begin m_hv[k] = 1'b0; m_ha[k] = 0; m_hd[k] = 32'h0; end
        m_starve = 0; m_we = 1'b0; m_waddr = 0; m_wdata = 32'h0; m_grant = 0;
        live = 1'b1;
      end else if (live) begin
        if (m_hv[2] && sel != 2) m_starve = (m_starve < 3) ? m_starve + 1 : 3;
        else                     m_starve = 0;
        m_we = (sel >= 0);
        if (sel >= 0) begin
          m_waddr = m_ha[sel];
          m_wdata = m_hd[sel];
          m_grant = 1 << sel;
        end else begin
          m_grant = 0;
        end
        for (int k = 0; k < 3; k++) begin
          if (rq[k] && rdy[k]) begin
            m_hv[k] = 1'b1; m_ha[k] = ra[k]; m_hd[k] = rdat[k];
          end else if (sel == k) begin
            m_hv[k] = 1'b0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.md_req = 1'b0; bus.ls_req = 1'b0; bus.dbg_req = 1'b0;
  endtask

  initial begin
    logic [2:0] exp_g [4];
    n_cmp = 0;
    n_bad = 0;
    idle_inputs();
    bus.md_addr = '0; bus.md_data = '0; bus.ls_addr = '0; bus.ls_data = '0;
    bus.dbg_addr = '0; bus.dbg_data = '0; bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_ready", {29'd0, bus.dbg_ready, bus.ls_ready, bus.md_ready}, 32'd7);

    // Single uncontested md write
    bus.md_req = 1'b1; bus.md_addr = 5'd5; bus.md_data = 32'hDEADBEEF;
    #1 check("t1_md_ready", 32'(bus.md_ready), 32'd1);
    step(); idle_inputs();
    step();
    #1;
    check("t1_rf_we", 32'(bus.rf_we), 32'd1);
    check("t1_waddr", 32'(bus.rf_waddr), 32'd5);
    check("t1_wdata", bus.rf_wdata, 32'hDEADBEEF);
    check("t1_grant", 32'(bus.grant), 32'd1);
    step();
    #1 check("t1_we_off", 32'(bus.rf_we), 32'd0);
    step();

    // Simultaneous requests drain in md, ls, dbg order
    bus.md_req = 1'b1;  bus.md_addr = 5'd1;  bus.md_data = 32'h11;
    bus.ls_req = 1'b1;  bus.ls_addr = 5'd2;  bus.ls_data = 32'h22;
    bus.dbg_req = 1'b1; bus.dbg_addr = 5'd3; bus.dbg_data = 32'h33;
    #1 check("t2_stall", 32'(bus.stall), 32'd0);
    step(); idle_inputs();
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      check("t2_grant", 32'(bus.grant), 32'd1 << k);
      check("t2_waddr", 32'(bus.rf_waddr), 32'(k + 1));
    end
    step(); step();

    // Debug starvation: promoted on the 4th slot while md/ls keep requesting
    bus.md_req = 1'b1;  bus.md_addr = 5'd10; bus.md_data = 32'hA0;
    bus.ls_req = 1'b1;  bus.ls_addr = 5'd11; bus.ls_data = 32'h5500_00FF;
    bus.dbg_req = 1'b1; bus.dbg_addr = 5'd12; bus.dbg_data = 32'hDB;
    step();
    bus.dbg_req = 1'b0;
    bus.ls_data = 32'h5500_0000;
    #1;
    check("t3_stall", 32'(bus.stall), 32'd1);
    check("t3_ls_ready", 32'(bus.ls_ready), 32'd0);
    exp_g = '{3'b001, 3'b001, 3'b001, 3'b100};
    for (int k = 0; k < 4; k++) begin
      step();
      bus.ls_data = 32'h5500_0001 + 32'(k);
      #1 check("t3_grant", 32'(bus.grant), 32'(exp_g[k]));
    end
    idle_inputs();
    step();
    #1 check("t3_md_last", 32'(bus.grant), 32'd1);
    step();
    #1;
    check("t3_ls_grant", 32'(bus.grant), 32'd2);
    check("t3_ls_data", bus.rf_wdata, 32'h5500_00FF);
    step(); step();

    // Hazard tracking on address 7, none on 8
    bus.rd_addr_a = 5'd7; bus.rd_addr_b = 5'd8;
    bus.md_req = 1'b1; bus.md_addr = 5'd7; bus.md_data = 32'h77;
    #1 check("t5_haz_pre", 32'(bus.hazard_a), 32'd0);
    step(); idle_inputs();
    #1;
    check("t5_haz_hold", 32'(bus.hazard_a), 32'd1);
    check("t5_hazb_hold", 32'(bus.hazard_b), 32'd0);
    step();
    #1;
    check("t5_we", 32'(bus.rf_we), 32'd1);
    check("t5_haz_we", 32'(bus.hazard_a), 32'd1);
    step();
    #1;
    check("t5_haz_clr", 32'(bus.hazard_a), 32'd0);
    check("t5_hazb_clr", 32'(bus.hazard_b), 32'd0);

    // Reset with all holds valid discards them
    bus.md_req = 1'b1; bus.ls_req = 1'b1; bus.dbg_req = 1'b1;
    step(); idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("t6_rf_we", 32'(bus.rf_we), 32'd0);
    check("t6_grant", 32'(bus.grant), 32'd0);
    check("t6_ready", {29'd0, bus.dbg_ready, bus.ls_ready, bus.md_ready}, 32'd7);
    step();
    #1 check("t6_no_we", 32'(bus.rf_we), 32'd0);

    // Randomized traffic checked by the model
    for (int n = 0; n < 500; n++) begin
      bus.md_req   = ($urandom_range(0, 99) < 60);
      bus.ls_req   = ($urandom_range(0, 99) < 50);
      bus.dbg_req  = ($urandom_range(0, 99) < 30);
      bus.md_addr  = 5'($urandom_range(0, 7));
      bus.ls_addr  = 5'($urandom_range(0, 7));
      bus.dbg_addr = 5'($urandom_range(0, 7));
      bus.md_data  = $urandom;
      bus.ls_data  = $urandom;
      bus.dbg_data = $urandom;
      bus.rd_addr_a = 5'($urandom_range(0, 7));
      bus.rd_addr_b = 5'($urandom_range(0, 7));
      reset = ($urandom_range(0, 63) == 0);
      step();
    end
    reset = 1'b0;
    idle_inputs();
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_b_write_arbiter.md
# regfile_b_write_arbiter

Arbitrates the second register-file write port (port B) among three requesters: the multiply/divide unit (high result), the load/store unit (post-increment address writeback), and the debug interface. Each requester gets a one-entry holding register, so a losing write is parked rather than lost. A starvation counter guarantees debug progress. The block also exports hazard flags so the operand-fetch stage can stall on reads of registers with pending port-B writes. It sits between the execute/memory stages and the register file, downstream of the port-B source-select control.

## Interface
Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- STARVE_MAX, 3, consecutive debug losses before debug is promoted to top priority

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- md_req / md_addr / md_data  in  1 / ADDR_W / DATA_W  multiply/divide high-result write request
- md_ready  out  1  md request accepted this cycle
- ls_req / ls_addr / ls_data  in  1 / ADDR_W / DATA_W  load/store address writeback request
- ls_ready  out  1  ls request accepted this cycle
- dbg_req / dbg_addr / dbg_data  in  1 / ADDR_W / DATA_W  debug register write request
- dbg_ready  out  1  debug request accepted this cycle
- rd_addr_a, rd_addr_b  in  ADDR_W each  operand-fetch read addresses
- rf_we  out  1  port-B write enable (registered)
- rf_waddr / rf_wdata  out  ADDR_W / DATA_W  port-B address/data (registered)
- grant  out  3  one-hot {dbg, ls, md}, registered, marks the source of the current rf_we
- stall  out  1  pipeline stall request (combinational)
- hazard_a, hazard_b  out  1 each  read address matches a pending port-B write (combinational)

## Operation
- Per requester i: hold_valid[i], hold_addr[i], hold_data[i].
- ready_i = !hold_valid[i] || issue_i, where issue_i means the entry is selected for issue this cycle. Handshake: the transfer happens when req_i && ready_i. On transfer, the addr/data are captured into hold[i] and hold_valid[i] is set.
- Issue selection each cycle, among valid holds only:
  - Default priority: md > ls > dbg.
  - If starve_cnt == STARVE_MAX, priority is dbg > md > ls.
- Exactly one entry issues per cycle, if any hold is valid. The issued entry's hold_valid clears, unless refilled by a same-cycle transfer.
- Issue registers rf_we=1, rf_waddr, rf_wdata and grant on the next edge. With no issue: rf_we=0, grant=0, and rf_waddr/rf_wdata hold their values.
- starve_cnt (2 bits, saturating):
  - increments when hold_valid[dbg] && dbg not issued;
  - clears when dbg issues or hold_valid[dbg]=0.
- Same-address writes from different requesters are written in issue order. The last write wins.
- stall = (md_req && !md_ready) || (ls_req && !ls_ready). Debug back-pressure never stalls the pipeline.
- hazard_x = 1 if any hold_valid[i] && hold_addr[i]==rd_addr_x, or rf_we && rf_waddr==rd_addr_x. Address 0 is not special-cased.

## Timing
- Reset values: all hold_valid=0, starve_cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0, grant=0. Consequently md/ls/dbg_ready=1, stall=0, hazard_a=hazard_b=0.
- Reset asserted mid-operation discards all parked writes. No rf_we occurs in the cycle after the reset edge.
- Uncontested latency: request accepted at edge N, issue selected in cycle N..N+1, rf_we high in the cycle after edge N+1 (2 edges from req to write).
- Back-to-back requests from one requester with no competition sustain 1 write/cycle: the issue frees the hold in the same cycle it refills.
- Worst-case md wait: 1 issue slot (when debug is promoted).
- Worst-case dbg wait: STARVE_MAX+1 issue slots.
- ready, stall and hazard are combinational from current state and inputs. They must not depend on rf_we of the same cycle.

## Test plan
- Reset, then a single md_req (addr 5, data 0xDEADBEEF) -> md_ready=1; two edges later rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, grant=001; following cycle rf_we=0.
- md, ls and dbg request simultaneously (addrs 1/2/3) -> writes issue in order md, ls, dbg on 3 consecutive cycles; grant 001, 010, 100; no stall because the holds drain.
- Continuous md and ls requests with a parked dbg write -> dbg issues on the 4th slot after parking (STARVE_MAX=3); starve_cnt returns to 0.
- hold[ls] full and not issued while ls_req=1 -> ls_ready=0, stall=1 until ls issues; the data offered while stalled is captured only on the ready cycle.
- rd_addr_a=7 while a hold targets 7 -> hazard_a=1 until the cycle after rf_we with rf_waddr=7; rd_addr_b=8 -> hazard_b=0 throughout.
- Reset asserted with all three holds valid -> no rf_we afterward; all ready=1, grant=0.
